// File: rtl/fdiv_issue_ctrl.sv
// fdiv_issue_ctrl: single-outstanding request/response front-end for the
// IEEE single-precision divider. Sequences an operand pair into the
// divider's A and B handshakes, collects Z, and returns it with exception
// flags. A watchdog pulses the divider reset if Z never arrives.
module fdiv_issue_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] NAN_VALUE      = 32'hFFC00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] req_a,
    input  logic [31:0] req_b,
    input  logic        req_stb,
    output logic        req_ack,
    output logic [31:0] resp_z,
    output logic [3:0]  resp_flags,
    output logic        resp_stb,
    input  logic        resp_ack,
    output logic [31:0] div_a,
    output logic        div_a_stb,
    input  logic        div_a_ack,
    output logic [31:0] div_b,
    output logic        div_b_stb,
    input  logic        div_b_ack,
    input  logic [31:0] div_z,
    input  logic        div_z_stb,
    output logic        div_z_ack,
    output logic        div_rst,
    output logic [15:0] op_count
);

    typedef enum logic [2:0] {
        IDLE,
        SEND_A,
        SEND_B,
        WAIT_Z,
        RESP
    } state_t;

    localparam logic [15:0] WD_LAST = 16'(TIMEOUT_CYCLES - 1);

    // Flag bit positions on resp_flags
    localparam int unsigned F_DIV0  = 0;
    localparam int unsigned F_INV   = 1;
    localparam int unsigned F_OVF   = 2;
    localparam int unsigned F_TMO   = 3;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == 8'hFF) && (v[22:0] == '0);
    endfunction

    function automatic logic is_zero(input logic [31:0] v);
        return (v[30:23] == 8'h00) && (v[22:0] == '0);
    endfunction

    function automatic logic is_finite(input logic [31:0] v);
        return v[30:23] != 8'hFF;
    endfunction

    state_t      state, state_d;

    logic        req_ack_d;
    logic        resp_stb_d;
    logic        div_a_stb_d;
    logic        div_b_stb_d;
    logic        div_z_ack_d;
    logic        div_rst_d;
    logic [31:0] resp_z_d;
    logic [3:0]  resp_flags_d;
    logic [31:0] div_a_d;
    logic [31:0] div_b_d;
    logic [15:0] op_count_d;
    logic [15:0] watchdog, watchdog_d;

    // Latched operands and their operand-class results
    logic [31:0] op_a, op_a_d;
    logic [31:0] op_b, op_b_d;
    logic        inv_flag, inv_flag_d;
    logic        div0_flag, div0_flag_d;
    logic        ovf_ok, ovf_ok_d;

    // Operand classification of the incoming request
    logic        cls_inv;
    logic        cls_div0;
    logic        cls_ovf_ok;
    logic        z_is_inf;

    // Operand class flags computed from the raw request fields
    always_comb begin
        cls_inv    = is_nan(req_a) || is_nan(req_b)
                   || (is_inf(req_a) && is_inf(req_b))
                   || (is_zero(req_a) && is_zero(req_b))
                   || (is_inf(req_a) && is_zero(req_b));
        cls_div0   = is_zero(req_b) && is_finite(req_a) && !is_zero(req_a);
        cls_ovf_ok = is_finite(req_a) && is_finite(req_b) && !is_zero(req_b);
        z_is_inf   = is_inf(div_z);
    end

    // State and registered-output update with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            req_ack    <= 1'b0;
            resp_stb   <= 1'b0;
            div_a_stb  <= 1'b0;
            div_b_stb  <= 1'b0;
            div_z_ack  <= 1'b0;
            div_rst    <= 1'b0;
            resp_z     <= '0;
            resp_flags <= '0;
            div_a      <= '0;
            div_b      <= '0;
            op_count   <= '0;
            watchdog   <= '0;
            op_a       <= '0;
            op_b       <= '0;
            inv_flag   <= 1'b0;
            div0_flag  <= 1'b0;
            ovf_ok     <= 1'b0;
        end else begin
            state      <= state_d;
            req_ack    <= req_ack_d;
            resp_stb   <= resp_stb_d;
            div_a_stb  <= div_a_stb_d;
            div_b_stb  <= div_b_stb_d;
            div_z_ack  <= div_z_ack_d;
            div_rst    <= div_rst_d;
            resp_z     <= resp_z_d;
            resp_flags <= resp_flags_d;
            div_a      <= div_a_d;
            div_b      <= div_b_d;
            op_count   <= op_count_d;
            watchdog   <= watchdog_d;
            op_a       <= op_a_d;
            op_b       <= op_b_d;
            inv_flag   <= inv_flag_d;
            div0_flag  <= div0_flag_d;
            ovf_ok     <= ovf_ok_d;
        end
    end

    // Next-state and next-output logic; every register holds unless changed,
    // except div_rst which is a single-cycle pulse
    always_comb begin
        state_d      = state;
        req_ack_d    = req_ack;
        resp_stb_d   = resp_stb;
        div_a_stb_d  = div_a_stb;
        div_b_stb_d  = div_b_stb;
        div_z_ack_d  = div_z_ack;
        div_rst_d    = 1'b0;
        resp_z_d     = resp_z;
        resp_flags_d = resp_flags;
        div_a_d      = div_a;
        div_b_d      = div_b;
        op_count_d   = op_count;
        watchdog_d   = watchdog;
        op_a_d       = op_a;
        op_b_d       = op_b;
        inv_flag_d   = inv_flag;
        div0_flag_d  = div0_flag;
        ovf_ok_d     = ovf_ok;

        case (state)
            IDLE: begin
                req_ack_d = 1'b1;
                if (req_stb && req_ack) begin
                    op_a_d      = req_a;
                    op_b_d      = req_b;
                    inv_flag_d  = cls_inv;
                    div0_flag_d = cls_div0;
                    ovf_ok_d    = cls_ovf_ok;
                    req_ack_d   = 1'b0;
                    state_d     = SEND_A;
                end
            end

            SEND_A: begin
                div_a_d     = op_a;
                div_a_stb_d = 1'b1;
                if (div_a_stb && div_a_ack) begin
                    div_a_stb_d = 1'b0;
                    state_d     = SEND_B;
                end
            end

            SEND_B: begin
                div_b_d     = op_b;
                div_b_stb_d = 1'b1;
                if (div_b_stb && div_b_ack) begin
                    div_b_stb_d = 1'b0;
                    watchdog_d  = '0;
                    state_d     = WAIT_Z;
                end
            end

            WAIT_Z: begin
                div_z_ack_d = 1'b1;
                watchdog_d  = watchdog + 16'd1;
                // A Z transfer wins over a timeout landing in the same cycle
                if (div_z_stb && div_z_ack) begin
                    div_z_ack_d          = 1'b0;
                    resp_z_d             = div_z;
                    resp_flags_d         = '0;
                    resp_flags_d[F_DIV0] = div0_flag;
                    resp_flags_d[F_INV]  = inv_flag;
                    resp_flags_d[F_OVF]  = z_is_inf && ovf_ok;
                    state_d              = RESP;
                end else if (watchdog == WD_LAST) begin
                    div_z_ack_d          = 1'b0;
                    div_rst_d            = 1'b1;
                    resp_z_d             = NAN_VALUE;
                    resp_flags_d         = '0;
                    resp_flags_d[F_TMO]  = 1'b1;
                    state_d              = RESP;
                end
            end

            RESP: begin
                resp_stb_d = 1'b1;
                if (resp_stb && resp_ack) begin
                    resp_stb_d = 1'b0;
                    op_count_d = op_count + 16'd1;
                    state_d    = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fdiv_issue_ctrl.sv
// Testbench for fdiv_issue_ctrl: table of operand/flag vectors through a
// stub divider, plus timeout, response stall and mid-operation reset runs.
module tb_fdiv_issue_ctrl;

    localparam int unsigned TMO = 160;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] req_a, req_b;
    logic        req_stb;
    logic        req_ack;
    logic [31:0] resp_z;
    logic [3:0]  resp_flags;
    logic        resp_stb;
    logic        resp_ack;
    logic [31:0] div_a;
    logic        div_a_stb;
    logic        div_a_ack;
    logic [31:0] div_b;
    logic        div_b_stb;
    logic        div_b_ack;
    logic [31:0] div_z;
    logic        div_z_stb;
    logic        div_z_ack;
    logic        div_rst;
    logic [15:0] op_count;

    always #5 clk = ~clk;

    fdiv_issue_ctrl #(
        .TIMEOUT_CYCLES(TMO),
        .NAN_VALUE(32'hFFC00000)
    ) dut (
        .clk(clk), .rst(rst),
        .req_a(req_a), .req_b(req_b), .req_stb(req_stb), .req_ack(req_ack),
        .resp_z(resp_z), .resp_flags(resp_flags), .resp_stb(resp_stb), .resp_ack(resp_ack),
        .div_a(div_a), .div_a_stb(div_a_stb), .div_a_ack(div_a_ack),
        .div_b(div_b), .div_b_stb(div_b_stb), .div_b_ack(div_b_ack),
        .div_z(div_z), .div_z_stb(div_z_stb), .div_z_ack(div_z_ack),
        .div_rst(div_rst), .op_count(op_count)
    );

    // ---------------- stub divider ----------------
    logic        stub_answer = 1'b1;
    logic [31:0] cur_dz = '0;
    logic        got_b = 1'b0;
    logic        zstb = 1'b0;
    logic [31:0] zdata = '0;
    logic        stray_stb = 1'b0;

    assign div_z_stb = zstb | stray_stb;
    assign div_z     = stray_stb ? 32'h12345678 : zdata;

    always @(posedge clk) begin
        if (rst || div_rst) begin
            got_b <= 1'b0;
            zstb  <= 1'b0;
        end else begin
            if (div_b_stb && div_b_ack) got_b <= 1'b1;
            if (got_b && stub_answer && !zstb) begin
                zstb  <= 1'b1;
                zdata <= cur_dz;
                got_b <= 1'b0;
            end
            if (zstb && div_z_ack) zstb <= 1'b0;
        end
    end

    // ---------------- scoreboard / checking ----------------
    typedef struct {
        logic [31:0] z;
        logic [3:0]  f;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   failures = 0;
    int   pops = 0;
    int   exp_ops = 0;
    int   ack_cycles = 0;
    int   rst_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // Response monitor: a transfer happens on the posedge after this sample
    always @(negedge clk) begin
        if (!rst && resp_stb && resp_ack) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_resp actual=%h required=none", resp_z);
            end else begin
                mon_e = sb.pop_front();
                chk("resp_z", resp_z, mon_e.z);
                chk("resp_flags", 32'(resp_flags), 32'(mon_e.f));
            end
            pops++;
        end
    end

    // Divider-side activity counters
    always @(negedge clk) begin
        if (div_z_ack) ack_cycles++;
        if (div_rst)   rst_pulses++;
    end

    task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] dz, input logic [31:0] ez,
                            input logic [3:0] ef);
        int n;
        n = 0;
        cur_dz = dz;
        @(negedge clk);
        req_a   = a;
        req_b   = b;
        req_stb = 1'b1;
        while (!req_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("req_ack_wait", 32'(req_ack), 32'd1);
        sb.push_back('{z: ez, f: ef});
        @(negedge clk);
        req_stb = 1'b0;
    endtask

    task automatic wait_resp(input string name);
        int start;
        int n;
        start = pops;
        n = 0;
        while (pops == start && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_resp_seen"}, 32'(pops != start), 32'd1);
        if (pops != start) exp_ops++;
        @(posedge clk);
        #1;
        chk({name, "_op_count"}, 32'(op_count), 32'(exp_ops));
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req_ack"},    32'(req_ack),    '0);
        chk({tag, "_resp_stb"},   32'(resp_stb),   '0);
        chk({tag, "_div_a_stb"},  32'(div_a_stb),  '0);
        chk({tag, "_div_b_stb"},  32'(div_b_stb),  '0);
        chk({tag, "_div_z_ack"},  32'(div_z_ack),  '0);
        chk({tag, "_div_rst"},    32'(div_rst),    '0);
        chk({tag, "_resp_z"},     resp_z,          '0);
        chk({tag, "_resp_flags"}, 32'(resp_flags), '0);
        chk({tag, "_div_a"},      div_a,           '0);
        chk({tag, "_div_b"},      div_b,           '0);
        chk({tag, "_op_count"},   32'(op_count),   '0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] dz;
        logic [31:0] ez;
        logic [3:0]  ef;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;

        vecs[0] = '{32'h40C00000, 32'h40400000, 32'h40000000, 32'h40000000, 4'b0000};
        vecs[1] = '{32'h3F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 4'b0001};
        vecs[2] = '{32'h00000000, 32'h80000000, 32'hFFC00000, 32'hFFC00000, 4'b0010};
        vecs[3] = '{32'h7F800000, 32'h7F800000, 32'hFFC00000, 32'hFFC00000, 4'b0010};
        vecs[4] = '{32'h7F000000, 32'h00800000, 32'h7F800000, 32'h7F800000, 4'b0100};
        vecs[5] = '{32'h7FC00000, 32'h3F800000, 32'h7FC00000, 32'h7FC00000, 4'b0010};
        vecs[6] = '{32'h7F800000, 32'h00000000, 32'h7F800000, 32'h7F800000, 4'b0010};
        vecs[7] = '{32'h00000000, 32'h3F800000, 32'h00000000, 32'h00000000, 4'b0000};
        vecs[8] = '{32'h7F800000, 32'h40000000, 32'h7F800000, 32'h7F800000, 4'b0000};
        vecs[9] = '{32'h3F800000, 32'h00000001, 32'h7F800000, 32'h7F800000, 4'b0100};

        rst       = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_stb   = 1'b0;
        resp_ack  = 1'b1;
        div_a_ack = 1'b1;
        div_b_ack = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b0;

        // Table-driven operand/flag vectors
        for (int i = 0; i < 10; i++) begin
            send_req(vecs[i].a, vecs[i].b, vecs[i].dz, vecs[i].ez, vecs[i].ef);
            wait_resp("vec");
        end

        // Watchdog timeout: divider never answers
        stub_answer = 1'b0;
        @(negedge clk);
        ack_cycles = 0;
        rst_pulses = 0;
        send_req(32'h3F800000, 32'h40000000, 32'h0, 32'hFFC00000, 4'b1000);
        wait_resp("timeout");
        chk("timeout_wait_cycles", 32'(ack_cycles), 32'(TMO - 1));
        chk("timeout_div_rst_pulse", 32'(rst_pulses), 32'd1);
        stub_answer = 1'b1;
        send_req(32'h40C00000, 32'h40400000, 32'h40000000, 32'h40000000, 4'b0000);
        wait_resp("after_timeout");

        // Response stall with a stray divider result pending
        resp_ack = 1'b0;
        send_req(32'h41200000, 32'h40000000, 32'h40A00000, 32'h40A00000, 4'b0000);
        n = 0;
        while (!resp_stb && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("stall_resp_stb_seen", 32'(resp_stb), 32'd1);
        stray_stb = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("stall_resp_z", resp_z, 32'h40A00000);
            chk("stall_resp_flags", 32'(resp_flags), 32'd0);
            chk("stall_req_ack", 32'(req_ack), 32'd0);
            chk("stall_resp_stb", 32'(resp_stb), 32'd1);
        end
        stray_stb = 1'b0;
        @(posedge clk);
        #1;
        resp_ack = 1'b1;
        wait_resp("stall");

        // Reset in the middle of WAIT_Z
        stub_answer = 1'b0;
        send_req(32'h3F800000, 32'h3F800000, 32'h0, 32'h0, 4'b0000);
        n = 0;
        while (!div_z_ack && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("midrst_wait_z_seen", 32'(div_z_ack), 32'd1);
        repeat (10) @(negedge clk);
        rst_pulses = 0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_ops = 0;
        check_reset_vals("midrst");
        repeat (3) @(negedge clk);
        chk("midrst_no_div_rst", 32'(rst_pulses), 32'd0);
        stub_answer = 1'b1;
        send_req(32'h40C00000, 32'h40400000, 32'h40000000, 32'h40000000, 4'b0000);
        wait_resp("after_midrst");

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "simulation time limit");
    end

endmodule
